// File: rtl/meissa_controller.sv
// Job sequencer for the MAC array: weight tile load, vector streaming, result strobes.
// Optional perf counters (perf_cycles/perf_stalls) under `define MEISSA_CTRL_PERF_EN.
module meissa_controller #(
  parameter int DATA_WIDTH   = 16,
  parameter int COLUMN_WIDTH = 9,
  parameter int MAC_LATENCY  = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [CNT_WIDTH-1:0]               num_vectors,
  output logic                               busy,
  output logic                               done,
  output logic                               w_req,
  input  logic                               w_ack,
  output logic                               arr_weight_load,
  input  logic                               din_valid,
  output logic                               din_ready,
  input  logic [DATA_WIDTH*COLUMN_WIDTH-1:0] din_data,
  output logic [DATA_WIDTH*COLUMN_WIDTH-1:0] arr_datain,
  output logic                               res_valid,
  output logic [CNT_WIDTH-1:0]               res_index
`ifdef MEISSA_CTRL_PERF_EN
  ,
  output logic [31:0]                        perf_cycles,
  output logic [31:0]                        perf_stalls
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_WLOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                              r_state;
  logic                                r_busy;
  logic                                r_done;
  logic                                r_w_req;
  logic                                r_wload;
  logic                                r_din_ready;
  logic [CNT_WIDTH-1:0]                r_cnt;
  logic [CNT_WIDTH-1:0]                r_num;
  logic [DATA_WIDTH*COLUMN_WIDTH-1:0]  r_dat;
  logic [MAC_LATENCY-1:0]              r_vld;
  logic [CNT_WIDTH-1:0]                r_idx [MAC_LATENCY];
  logic                                r_res_valid;
  logic [CNT_WIDTH-1:0]                r_res_index;

  logic w_acc;
  logic w_last;

  assign w_acc  = r_din_ready & din_valid;
  assign w_last = (r_cnt == (r_num - CNT_WIDTH'(1)));

  // din_ready is cleared on the edge of the final accept, so it is low
  // from the cycle the count reaches num_vectors.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_w_req     <= 1'b0;
      r_wload     <= 1'b0;
      r_din_ready <= 1'b0;
      r_cnt       <= '0;
      r_num       <= '0;
    end else begin
      r_done  <= 1'b0;
      r_wload <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num  <= num_vectors;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (num_vectors == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_LOAD_W;
              r_w_req <= 1'b1;
            end
          end
        end
        S_LOAD_W: begin
          if (w_ack) begin
            r_w_req <= 1'b0;
            r_wload <= 1'b1;
            r_state <= S_WLOAD;
          end
        end
        S_WLOAD: begin
          r_state     <= S_STREAM;
          r_din_ready <= 1'b1;
        end
        S_STREAM: begin
          if (w_acc) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
            if (w_last) begin
              r_din_ready <= 1'b0;
              r_state     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (r_vld == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_w_req     <= 1'b0;
          r_din_ready <= 1'b0;
        end
      endcase
    end
  end

  // Valid/index pipe models the array latency; res_* is one stage past its tail.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dat       <= '0;
      r_vld       <= '0;
      r_res_valid <= 1'b0;
      r_res_index <= '0;
      for (int unsigned i = 0; i < MAC_LATENCY; i++) r_idx[i] <= '0;
    end else begin
      if (w_acc) r_dat <= din_data;
      r_vld[0] <= w_acc;
      r_idx[0] <= r_cnt;
      for (int unsigned i = 1; i < MAC_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_idx[i] <= r_idx[i-1];
      end
      r_res_valid <= r_vld[MAC_LATENCY-1];
      r_res_index <= r_idx[MAC_LATENCY-1];
    end
  end

`ifdef MEISSA_CTRL_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_stalls;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_cycles <= '0;
      r_perf_stalls <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_perf_cycles <= '0;
      r_perf_stalls <= '0;
    end else begin
      if (r_busy && r_perf_cycles != '1) r_perf_cycles <= r_perf_cycles + 32'd1;
      if (r_din_ready && !din_valid && r_perf_stalls != '1)
        r_perf_stalls <= r_perf_stalls + 32'd1;
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_stalls = r_perf_stalls;
`endif

  assign busy            = r_busy;
  assign done            = r_done;
  assign w_req           = r_w_req;
  assign arr_weight_load = r_wload;
  assign din_ready       = r_din_ready;
  assign arr_datain      = r_dat;
  assign res_valid       = r_res_valid;
  assign res_index       = r_res_index;

endmodule

// File: tb/tb_meissa_controller.sv
// Directed bench for meissa_controller: per-cycle output traces compared to hand-derived patterns.
module tb_meissa_controller;

  logic          clk;
  logic          reset;
  logic          start;
  logic [15:0]   num_vectors;
  logic          busy;
  logic          done;
  logic          w_req;
  logic          w_ack;
  logic          arr_weight_load;
  logic          din_valid;
  logic          din_ready;
  logic [143:0]  din_data;
  logic [143:0]  arr_datain;
  logic          res_valid;
  logic [15:0]   res_index;
`ifdef MEISSA_CTRL_PERF_EN
  logic [31:0]   perf_cycles;
  logic [31:0]   perf_stalls;
`endif

  int checks = 0;
  int errors = 0;

  logic [63:0]  rec_wreq, rec_wload, rec_dr, rec_rv, rec_done, rec_busy;
  logic [15:0]  rec_idx [64];
  logic [143:0] rec_dat [64];

  meissa_controller #(
    .DATA_WIDTH(16),
    .COLUMN_WIDTH(9),
    .MAC_LATENCY(1),
    .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .num_vectors(num_vectors),
    .busy(busy),
    .done(done),
    .w_req(w_req),
    .w_ack(w_ack),
    .arr_weight_load(arr_weight_load),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .din_data(din_data),
    .arr_datain(arr_datain),
    .res_valid(res_valid),
    .res_index(res_index)
`ifdef MEISSA_CTRL_PERF_EN
    ,
    .perf_cycles(perf_cycles),
    .perf_stalls(perf_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [143:0] dat(input int c);
    logic [15:0] e;
    e = 16'hA000 + 16'(c);
    return {9{e}};
  endfunction

  // Drives n cycles from bit-vector stimulus; cycle c's outputs are recorded before its inputs are applied.
  task automatic run(input int n, input logic [15:0] nv, input logic [63:0] st,
                     input logic [63:0] ack, input logic [63:0] vld, input logic [63:0] rst);
    rec_wreq = '0; rec_wload = '0; rec_dr = '0; rec_rv = '0; rec_done = '0; rec_busy = '0;
    for (int i = 0; i < 64; i++) begin
      rec_idx[i] = '0;
      rec_dat[i] = '0;
    end
    for (int c = 0; c < n; c++) begin
      rec_wreq[c]  = w_req;
      rec_wload[c] = arr_weight_load;
      rec_dr[c]    = din_ready;
      rec_rv[c]    = res_valid;
      rec_done[c]  = done;
      rec_busy[c]  = busy;
      rec_idx[c]   = res_index;
      rec_dat[c]   = arr_datain;
      start       = st[c];
      w_ack       = ack[c];
      din_valid   = vld[c];
      reset       = rst[c];
      num_vectors = nv;
      din_data    = dat(c);
      @(posedge clk); #1;
    end
    start = 1'b0; w_ack = 1'b0; din_valid = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; w_ack = 1'b0; din_valid = 1'b0;
    num_vectors = '0; din_data = '1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, w_req, arr_weight_load, din_ready, res_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {busy, done, w_req, arr_weight_load, din_ready, res_valid});
    end
    checks++;
    if (arr_datain !== '0 || res_index !== '0) begin
      errors++;
      $display("FAIL reset_data: got dat=%h idx=%h expected 0", arr_datain, res_index);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    run(13, 16'd4, 64'h1, 64'h4, '1, '0);
    checks++;
    if (rec_wreq !== 64'h6) begin errors++; $display("FAIL basic_wreq: got %h expected %h", rec_wreq, 64'h6); end
    checks++;
    if (rec_wload !== 64'h8) begin errors++; $display("FAIL basic_wload: got %h expected %h", rec_wload, 64'h8); end
    checks++;
    if (rec_dr !== 64'hF0) begin errors++; $display("FAIL basic_din_ready: got %h expected %h", rec_dr, 64'hF0); end
    checks++;
    if (rec_rv !== 64'h3C0) begin errors++; $display("FAIL basic_res_valid: got %h expected %h", rec_rv, 64'h3C0); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rec_idx[6+k] !== 16'(k)) begin
        errors++;
        $display("FAIL basic_res_index%0d: got %0d expected %0d", k, rec_idx[6+k], k);
      end
    end
    checks++;
    if (rec_done !== 64'h400) begin errors++; $display("FAIL basic_done: got %h expected %h", rec_done, 64'h400); end
    checks++;
    if (rec_busy !== 64'h7FE) begin errors++; $display("FAIL basic_busy: got %h expected %h", rec_busy, 64'h7FE); end
    checks++;
    if (rec_dat[5] !== dat(4) || rec_dat[8] !== dat(7) || rec_dat[12] !== dat(7)) begin
      errors++;
      $display("FAIL basic_datain: got %h/%h/%h expected %h/%h/%h",
               rec_dat[5][15:0], rec_dat[8][15:0], rec_dat[12][15:0], 16'hA004, 16'hA007, 16'hA007);
    end
  endtask

  task automatic test_zero_vectors;
    run(6, 16'd0, 64'h1, '1, '1, '0);
    checks++;
    if (rec_done !== 64'h2) begin errors++; $display("FAIL zero_done: got %h expected %h", rec_done, 64'h2); end
    checks++;
    if (rec_busy !== 64'h2) begin errors++; $display("FAIL zero_busy: got %h expected %h", rec_busy, 64'h2); end
    checks++;
    if ((rec_wreq | rec_wload | rec_dr | rec_rv) !== 64'h0) begin
      errors++;
      $display("FAIL zero_quiet: got wreq=%h wload=%h dr=%h rv=%h expected 0", rec_wreq, rec_wload, rec_dr, rec_rv);
    end
  endtask

  task automatic test_bubbles;
    run(13, 16'd3, 64'h1, 64'h4, 64'h190, '0);
    checks++;
    if (rec_dr !== 64'h1F0) begin errors++; $display("FAIL bub_din_ready: got %h expected %h", rec_dr, 64'h1F0); end
    checks++;
    if (rec_rv !== 64'h640) begin errors++; $display("FAIL bub_res_valid: got %h expected %h", rec_rv, 64'h640); end
    checks++;
    if (rec_idx[6] !== 16'd0 || rec_idx[9] !== 16'd1 || rec_idx[10] !== 16'd2) begin
      errors++;
      $display("FAIL bub_res_index: got %0d,%0d,%0d expected 0,1,2", rec_idx[6], rec_idx[9], rec_idx[10]);
    end
    checks++;
    if (rec_done !== 64'h800) begin errors++; $display("FAIL bub_done: got %h expected %h", rec_done, 64'h800); end
    checks++;
    if (rec_dat[5] !== dat(4) || rec_dat[6] !== dat(4) || rec_dat[7] !== dat(4)) begin
      errors++;
      $display("FAIL bub_hold: got %h/%h/%h expected %h", rec_dat[5][15:0], rec_dat[6][15:0],
               rec_dat[7][15:0], 16'hA004);
    end
    checks++;
    if (rec_dat[8] !== dat(7) || rec_dat[9] !== dat(8) || rec_dat[12] !== dat(8)) begin
      errors++;
      $display("FAIL bub_datain: got %h/%h/%h expected %h/%h/%h", rec_dat[8][15:0], rec_dat[9][15:0],
               rec_dat[12][15:0], 16'hA007, 16'hA008, 16'hA008);
    end
`ifdef MEISSA_CTRL_PERF_EN
    checks++;
    if (perf_stalls !== 32'd2) begin errors++; $display("FAIL perf_stalls: got %0d expected 2", perf_stalls); end
    checks++;
    if (perf_cycles !== 32'd11) begin errors++; $display("FAIL perf_cycles: got %0d expected 11", perf_cycles); end
`endif
  endtask

  task automatic test_slow_ack;
    run(13, 16'd1, 64'h1, 64'h21, '1, '0);
    checks++;
    if (rec_wreq !== 64'h3E) begin errors++; $display("FAIL slow_wreq: got %h expected %h", rec_wreq, 64'h3E); end
    checks++;
    if (rec_wload !== 64'h40) begin errors++; $display("FAIL slow_wload: got %h expected %h", rec_wload, 64'h40); end
    checks++;
    if (rec_dr !== 64'h80) begin errors++; $display("FAIL slow_din_ready: got %h expected %h", rec_dr, 64'h80); end
    checks++;
    if (rec_rv !== 64'h200 || rec_done !== 64'h400) begin
      errors++;
      $display("FAIL slow_result: got rv=%h done=%h expected rv=%h done=%h", rec_rv, rec_done, 64'h200, 64'h400);
    end
  endtask

  task automatic test_reset_midjob;
    run(16, 16'd6, 64'h1, 64'h4, '1, 64'h40);
    checks++;
    if (rec_dr !== 64'h70 || rec_rv !== 64'h40) begin
      errors++;
      $display("FAIL abort_pre: got dr=%h rv=%h expected dr=%h rv=%h", rec_dr, rec_rv, 64'h70, 64'h40);
    end
    checks++;
    if (rec_dat[6] !== dat(5)) begin
      errors++;
      $display("FAIL abort_datain_pre: got %h expected %h", rec_dat[6][15:0], 16'hA005);
    end
    checks++;
    if ({rec_busy[7], rec_done[7], rec_wreq[7], rec_wload[7], rec_dr[7], rec_rv[7]} !== 6'b0 ||
        rec_dat[7] !== '0 || rec_idx[7] !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got ctl=%b dat=%h idx=%h expected 0",
               {rec_busy[7], rec_done[7], rec_wreq[7], rec_wload[7], rec_dr[7], rec_rv[7]},
               rec_dat[7][15:0], rec_idx[7]);
    end
    checks++;
    if (rec_done !== 64'h0 || rec_busy !== 64'h7E) begin
      errors++;
      $display("FAIL abort_done: got done=%h busy=%h expected done=0 busy=%h", rec_done, rec_busy, 64'h7E);
    end
    run(11, 16'd2, 64'h1, 64'h4, '1, '0);
    checks++;
    if (rec_rv !== 64'hC0 || rec_idx[6] !== 16'd0 || rec_idx[7] !== 16'd1) begin
      errors++;
      $display("FAIL abort_rerun_res: got rv=%h idx=%0d,%0d expected rv=%h idx=0,1",
               rec_rv, rec_idx[6], rec_idx[7], 64'hC0);
    end
    checks++;
    if (rec_done !== 64'h100 || rec_busy !== 64'h1FE) begin
      errors++;
      $display("FAIL abort_rerun_done: got done=%h busy=%h expected done=%h busy=%h",
               rec_done, rec_busy, 64'h100, 64'h1FE);
    end
  endtask

  task automatic test_start_while_busy;
    run(12, 16'd2, 64'h321, 64'h4, '1, '0);
    checks++;
    if (rec_done !== 64'h100) begin errors++; $display("FAIL busy_start_done: got %h expected %h", rec_done, 64'h100); end
    checks++;
    if (rec_rv !== 64'hC0 || rec_dr !== 64'h30) begin
      errors++;
      $display("FAIL busy_start_stream: got rv=%h dr=%h expected rv=%h dr=%h", rec_rv, rec_dr, 64'hC0, 64'h30);
    end
    checks++;
    if (rec_busy !== 64'hDFE || rec_wreq !== 64'hC06) begin
      errors++;
      $display("FAIL busy_start_next: got busy=%h wreq=%h expected busy=%h wreq=%h",
               rec_busy, rec_wreq, 64'hDFE, 64'hC06);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_vectors();
    test_bubbles();
    test_slow_ack();
    test_reset_midjob();
    test_start_while_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
